// File: rtl/l2_write_buffer_if.sv
// l2_write_buffer_if: arbiter-side and L2-side signals of the write buffer
interface l2_write_buffer_if;
  logic         arb_read;
  logic         arb_write;
  logic [15:0]  arb_address;
  logic [127:0] arb_wdata;
  logic [127:0] arb_rdata;
  logic         arb_resp;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;
  logic         wb_empty;
  logic         wb_full;
  modport slave (
    input  arb_read, arb_write, arb_address, arb_wdata, l2_rdata, l2_resp,
    output arb_rdata, arb_resp, l2_read, l2_write, l2_address, l2_wdata, wb_empty, wb_full
  );
  modport master (
    output arb_read, arb_write, arb_address, arb_wdata, l2_rdata, l2_resp,
    input  arb_rdata, arb_resp, l2_read, l2_write, l2_address, l2_wdata, wb_empty, wb_full
  );
endinterface

// File: rtl/l2_write_buffer.sv
// l2_write_buffer: coalescing FIFO of write lines between arbiter and L2, with read-hit forwarding
module l2_write_buffer #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  l2_write_buffer_if.slave io_bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {U_IDLE, U_MISS, U_RESP} u_state_t;
  typedef enum logic [1:0] {D_IDLE, D_READ, D_WRITE} d_state_t;
  u_state_t r_u, w_u_nxt;
  d_state_t r_d, w_d_nxt;
  logic [15:0]   r_addr [DEPTH];
  logic [127:0]  r_data [DEPTH];
  logic [AW-1:0] r_head, r_tail, w_i, w_cidx;
  logic [AW:0]   r_count;
  logic [127:0]  r_rdata, r_l2_wdata, w_hit_data;
  logic [15:0]   r_l2_addr;
  logic w_rd, w_wr, w_hit, w_cmatch, w_drain_start, w_lock, w_pop, w_accept, w_push, w_coal, w_rd_hit, w_miss_done;
  assign w_rd          = io_bus.arb_read;
  assign w_wr          = io_bus.arb_write && !io_bus.arb_read;
  assign w_drain_start = r_d == D_IDLE && r_u != U_MISS && r_count != '0;
  assign w_lock        = r_d == D_WRITE || w_drain_start;
  assign w_pop         = r_d == D_WRITE && io_bus.l2_resp;
  assign w_accept      = r_u == U_IDLE && w_wr && (w_cmatch || r_count != FULL || w_pop);
  assign w_push        = w_accept && !w_cmatch;
  assign w_coal        = w_accept && w_cmatch;
  assign w_rd_hit      = r_u == U_IDLE && w_rd && w_hit;
  assign w_miss_done   = r_u == U_MISS && r_d == D_READ && io_bus.l2_resp;
  // Scan oldest to youngest; the head is excluded from coalescing once its drain is committed
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    w_cmatch   = 1'b0;
    w_cidx     = '0;
    w_i        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_i = r_head + AW'(k);
      if (k < int'(r_count) && r_addr[w_i] == io_bus.arb_address) begin
        w_hit      = 1'b1;
        w_hit_data = r_data[w_i];
        if (!(k == 0 && w_lock)) begin
          w_cmatch = 1'b1;
          w_cidx   = w_i;
        end
      end
    end
  end
  always_comb begin
    w_u_nxt = r_u;
    w_d_nxt = r_d;
    w_u_nxt = r_u == U_IDLE ? (w_rd ? (w_hit ? U_RESP : U_MISS) : (w_accept ? U_RESP : U_IDLE)) :
              r_u == U_MISS ? (w_miss_done ? U_RESP : U_MISS) : U_IDLE;
    w_d_nxt = r_d == D_IDLE ? (r_u == U_MISS ? D_READ : (r_count != '0 ? D_WRITE : D_IDLE)) :
              (io_bus.l2_resp ? D_IDLE : r_d);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_u        <= U_IDLE;
      r_d        <= D_IDLE;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rdata    <= '0;
      r_l2_addr  <= '0;
      r_l2_wdata <= '0;
    end else begin
      r_u     <= w_u_nxt;
      r_d     <= w_d_nxt;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      if (w_rd_hit) r_rdata <= w_hit_data;
      else if (w_miss_done) r_rdata <= io_bus.l2_rdata;
      if (r_d == D_IDLE && r_u == U_MISS) r_l2_addr <= io_bus.arb_address;
      else if (w_drain_start) begin
        r_l2_addr  <= r_addr[r_head];
        r_l2_wdata <= r_data[r_head];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= io_bus.arb_address;
      r_data[r_tail] <= io_bus.arb_wdata;
    end
    if (w_coal) r_data[w_cidx] <= io_bus.arb_wdata;
  end
  assign io_bus.arb_resp   = r_u == U_RESP;
  assign io_bus.arb_rdata  = r_rdata;
  assign io_bus.l2_read    = r_d == D_READ;
  assign io_bus.l2_write   = r_d == D_WRITE;
  assign io_bus.l2_address = r_l2_addr;
  assign io_bus.l2_wdata   = r_l2_wdata;
  assign io_bus.wb_empty   = r_count == '0 && r_d != D_WRITE;
  assign io_bus.wb_full    = r_count == FULL;
endmodule

// File: doc/l2_write_buffer.md
L2_WRITE_BUFFER -- requirements
Module: l2_write_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of buffered write lines (power of two, 2..8).
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 arb_read  input  1  read request from arbiter; held until arb_resp.
REQ-006 arb_write  input  1  write request from arbiter; held until arb_resp.
REQ-007 arb_address  input  16  line address from arbiter.
REQ-008 arb_wdata  input  128  write line from arbiter.
REQ-009 arb_rdata  output  128  read line to arbiter; valid when arb_resp=1.
REQ-010 arb_resp  output  1  one-cycle completion pulse to arbiter.
REQ-011 l2_read  output  1  read request to L2; held until l2_resp.
REQ-012 l2_write  output  1  write request to L2; held until l2_resp.
REQ-013 l2_address  output  16  address to L2.
REQ-014 l2_wdata  output  128  write line to L2.
REQ-015 l2_rdata  input  128  read line from L2; valid with l2_resp.
REQ-016 l2_resp  input  1  L2 completion, one cycle.
REQ-017 wb_empty  output  1  high when no entries are valid and no drain is in flight.
REQ-018 wb_full  output  1  high when count == DEPTH.

Function
REQ-019 SHALL hold a FIFO of DEPTH entries {address, data}, with head/tail pointers wrapping modulo DEPTH and count 0..DEPTH.
REQ-020 Upstream FSM SHALL have states U_IDLE, U_MISS, U_RESP; arb_resp = (state == U_RESP), so exactly one cycle.
REQ-021 In U_RESP the block SHALL ignore arb_read/arb_write (requests still high that cycle) and return to U_IDLE next cycle.
REQ-022 Write, request sampled at edge N, matching a valid non-draining entry: overwrite that entry's data (coalesce), count unchanged, arb_resp high in cycle N+1.
REQ-023 Write with no match and count < DEPTH: allocate at tail, count+1, arb_resp in N+1.
REQ-024 Write with no match and count == DEPTH: stall in U_IDLE; accept on the first edge after a drain pops, same-edge pop and push allowed (count unchanged).
REQ-025 Write matching only the entry currently being drained SHALL allocate a new entry, never modify the draining entry.
REQ-026 Read hitting the buffer: arb_rdata = youngest matching entry's data, arb_resp in N+1, no L2 access.
REQ-027 Read miss: go to U_MISS; issue l2_read with arb_address once downstream is idle; on l2_resp, latch l2_rdata into arb_rdata and go to U_RESP (arb_resp one cycle after l2_resp).
REQ-028 Downstream FSM SHALL have states D_IDLE, D_READ, D_WRITE, one L2 transaction outstanding at a time.
REQ-029 From D_IDLE, pending read miss SHALL take priority over starting a drain; drain starts when count > 0 and no read miss is pending.
REQ-030 D_WRITE SHALL drive l2_write with head address/data, hold until l2_resp, then pop head (head+1, count-1) and return to D_IDLE.
REQ-031 A started drain SHALL never be aborted; a read miss arriving mid-drain waits for D_IDLE.
REQ-032 l2_read and l2_write SHALL never be high simultaneously; l2_address/l2_wdata stable while either is high.
REQ-033 Simultaneous arb_read and arb_write SHALL be treated as a read (illegal from arbiter; defined for robustness).

Reset
REQ-034 On rst: count=0, head=tail=0, all entries invalid, both FSMs to idle, arb_resp=l2_read=l2_write=0, arb_rdata=l2_address=l2_wdata=0, wb_empty=1, wb_full=0.
REQ-035 Reset mid-operation SHALL discard buffered writes and any in-flight L2 transaction; no response pulses after reset deassertion.

Verification
REQ-036 Write 0x1000/data A, DEPTH=4 -> arb_resp one cycle later; wb_empty=0; later l2_write addr 0x1000 data A; after l2_resp wb_empty=1.
REQ-037 Write 0x2000/A then 0x2000/B before drain -> count stays 1; L2 sees single write of B.
REQ-038 Five distinct writes with L2 resp delayed 10 cycles -> wb_full after 4th; 5th arb_resp only after first drain's l2_resp.
REQ-039 Write 0x3000/C, then read 0x3000 -> arb_rdata=C one cycle after request, no l2_read.
REQ-040 Read 0x4000 miss while drain in flight -> l2_read issued after drain's l2_resp; arb_resp one cycle after read l2_resp with l2_rdata.
REQ-041 rst asserted during D_WRITE with count=3 -> l2_write drops immediately, count=0, wb_empty=1, no arb_resp.
